fifo_sync3: RTL and testbench

Parametrised synchronous FIFO, the next generation of `fifo_sync2` for the board demos and later datapath use. It adds:
- occupancy count, programmable almost-full/almost-empty flags and synchronous flush;
- sticky overflow/underflow error flags;
- a compile-time first-word-fall-through read mode.

It sits between debounced push-button or stream producers and consumers in the `clk` domain, and drops into the existing demo top level in place of `fifo_sync2`.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_ram.sv | 28 ++
 rtl/fifo_sync3.sv | 106 ++++++++++
 tb/tb_fifo_sync3.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO types and level-check helpers.
//   fifo_op_e      : accepted operation for one cycle (idle, write, read, both)
//   decode_op      : builds fifo_op_e from the accepted write/read pair
//   level_at_least : value >= level
//   level_at_most  : value <= level
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2,
        OP_RW   = 2'd3
    } fifo_op_e;

    function automatic fifo_op_e decode_op(input logic wr, input logic rd);
        return fifo_op_e'({rd, wr});
    endfunction

    function automatic logic level_at_least(input int value, input int level);
        return value >= level;
    endfunction

    function automatic logic level_at_most(input int value, input int level);
        return value <= level;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_BITS register file, synchronous write, asynchronous read.
//   clk   in  : write clock, rising edge
//   we    in  : write enable
//   waddr in  : write address
//   wdata in  : write data
//   raddr in  : read address
//   rdata out : mem[raddr], combinational
module fifo_ram #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    // Contents need no reset: the controller never exposes an unwritten word.
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync3.sv
// fifo_sync3: synchronous FIFO with occupancy count, programmable almost flags,
// synchronous flush and sticky overflow/underflow flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a
// registered read with latency 1.
//   clk          in  : clock, rising edge
//   rst_n        in  : asynchronous active-low reset
//   flush        in  : synchronous clear of pointers and count
//   clr_err      in  : clears overflow/underflow (a same-cycle error wins)
//   wr_en        in  : push request
//   data_in      in  : push data
//   rd_en        in  : pop request
//   data_out     out : read data
//   count        out : occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty out : status flags
//   overflow, underflow out : sticky error flags
module fifo_sync3
    import fifo_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 4,
    parameter int AF_LEVEL  = (1 << ADDR_BITS) - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 clr_err,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] data_out,
    output logic [ADDR_BITS:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow
);

    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS+1)'(1 << ADDR_BITS);

    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic                 wr_ok, rd_ok, ov_evt, un_evt;
    fifo_op_e             op;

    assign full         = count == FULL_COUNT;
    assign empty        = count == '0;
    assign almost_full  = level_at_least(int'(count), AF_LEVEL);
    assign almost_empty = level_at_most(int'(count), AE_LEVEL);

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign wr_ok  = !flush && wr_en && (!full || rd_en);
    assign rd_ok  = !flush && rd_en && !empty;
    assign ov_evt = !flush && wr_en && full && !rd_en;
    assign un_evt = !flush && rd_en && empty;
    assign op     = decode_op(wr_ok, rd_ok);

    fifo_ram #(
        .DATA_BITS(DATA_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk  (clk),
        .we   (wr_ok),
        .waddr(wr_ptr),
        .wdata(data_in),
        .raddr(rd_ptr),
        .rdata(head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
                if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
                count <= op == OP_WR ? count + 1'b1 :
                         op == OP_RD ? count - 1'b1 : count;
            end
            overflow  <= ov_evt || (overflow && !clr_err);
            underflow <= un_evt || (underflow && !clr_err);
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown directly from the register file while data is present.
    assign data_out = empty ? '0 : head;
`else
    // Head is captured at the popping edge, before the read pointer moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_out <= '0;
        else if (rd_ok) data_out <= head;
    end
`endif

endmodule

// File: tb/tb_fifo_sync3.sv
// tb_fifo_sync3: directed self-checking bench for fifo_sync3 (DATA_BITS=3,
// ADDR_BITS=4, AF_LEVEL=14, AE_LEVEL=2); follows FIFO_FWFT_EN like the RTL.
module tb_fifo_sync3;

    logic       clk = 1'b0;
    logic       rst_n, flush, clr_err, wr_en, rd_en;
    logic [2:0] data_in, data_out;
    logic [4:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] sb[$];
    int         mcount = 0;
    logic       mov = 1'b0, mun = 1'b0;
    logic [2:0] exp_dout = '0;

    fifo_sync3 #(
        .DATA_BITS(3),
        .ADDR_BITS(4),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .clr_err     (clr_err),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [2:0] dexp;
`ifdef FIFO_FWFT_EN
        dexp = mcount == 0 ? 3'd0 : sb[0];
`else
        dexp = exp_dout;
`endif
        chk("count", 32'(count), 32'(mcount));
        chk("full", 32'(full), 32'(mcount == 16));
        chk("empty", 32'(empty), 32'(mcount == 0));
        chk("almost_full", 32'(almost_full), 32'(mcount >= 14));
        chk("almost_empty", 32'(almost_empty), 32'(mcount <= 2));
        chk("overflow", 32'(overflow), 32'(mov));
        chk("underflow", 32'(underflow), 32'(mun));
        chk("data_out", 32'(data_out), 32'(dexp));
    endtask

    // One clock of stimulus: the model predicts acceptance, the scoreboard
    // receives written words and supplies the expected read word.
    task automatic cycle(input logic wr, input logic [2:0] din, input logic rd,
                         input logic fl, input logic ce);
        logic       wr_ok, rd_ok, ov_ev, un_ev;
        logic [2:0] popped;
        wr_en = wr; data_in = din; rd_en = rd; flush = fl; clr_err = ce;
        wr_ok  = !fl && wr && (mcount < 16 || rd);
        rd_ok  = !fl && rd && mcount > 0;
        ov_ev  = !fl && wr && mcount == 16 && !rd;
        un_ev  = !fl && rd && mcount == 0;
        popped = '0;
        if (rd_ok) popped = sb.pop_front();
`ifdef FIFO_FWFT_EN
        if (rd_ok) chk("fwft_head", 32'(data_out), 32'(popped));
`else
        if (rd_ok) exp_dout = popped;
`endif
        if (wr_ok) sb.push_back(din);
        if (fl) begin
            sb.delete();
            mcount = 0;
        end else begin
            mcount = mcount + int'(wr_ok) - int'(rd_ok);
        end
        mov = ov_ev || (mov && !ce);
        mun = un_ev || (mun && !ce);
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; clr_err = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all();

        // Fill with 1..7,0,1..7,0; then one rejected write.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 3'((i + 1) % 8), 1'b0, 1'b0, 1'b0);
            if (i == 12) chk("af_below_14", 32'(almost_full), 32'd0);
            if (i == 13) chk("af_at_14", 32'(almost_full), 32'd1);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd16);
        cycle(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);

        // Clear, then read+write while full: no overflow, 5 lands at the tail.
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("clr_alone", 32'(overflow), 32'd0);
        cycle(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        chk("full_rw_count", 32'(count), 32'd16);
        chk("full_rw_ovf", 32'(overflow), 32'd0);

        // Drain: last word is 5, then an empty read sets underflow.
        for (int i = 0; i < 16; i++) cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
        chk("drain_last", 32'(data_out), 32'd5);
`endif
        chk("drain_empty", 32'(empty), 32'd1);
        cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("unf_set", 32'(underflow), 32'd1);

        // Read+write while empty: write taken, read rejected.
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        chk("empty_rw_count", 32'(count), 32'd1);
        chk("empty_rw_unf", 32'(underflow), 32'd1);
        cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
`ifndef FIFO_FWFT_EN
        chk("empty_rw_data", 32'(data_out), 32'd6);
`endif

        // Flush at count 9 with a concurrent write; errors are kept.
        for (int i = 0; i < 9; i++) cycle(1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd9);
        cycle(1'b1, 3'd4, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_keeps_unf", 32'(underflow), 32'd1);

        // Error wins over a same-cycle clr_err; clr_err alone clears.
        for (int i = 0; i < 16; i++) cycle(1'b1, 3'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
        chk("err_wins", 32'(overflow), 32'd1);
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("clr_clears", 32'(overflow), 32'd0);

`ifdef FIFO_FWFT_EN
        // Fall-through: a word written to an empty FIFO shows without rd_en.
        cycle(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        chk("fwft_show", 32'(data_out), 32'd3);
        chk("fwft_not_empty", 32'(empty), 32'd0);
        cycle(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("fwft_popped", 32'(data_out), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
